dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
Shares the single-port data memory between the CPU MEM stage and a debug/loader port. Sequences each access through a fixed 3-state FSM, with round-robin fairness when both ports request. Drives the pipeline stall for the MEM stage and keeps a saturating count of CPU wait cycles, so the bench can report memory-induced stalls. Sits between the CPU pipeline MEM stage, the debug port and the data memory.

Parameters:
ADDR_W, 32, byte address width of both request ports
DATA_W, 32, word width (whole-word accesses only)
MEM_BYTES, 32, memory size in bytes; addresses >= MEM_BYTES are rejected
CNT_W, 16, width of the wait-cycle counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
start_i  in  1  CPU run enable; when 0, CPU requests are not granted
cpu_req_i  in  1  CPU access request, held until cpu_ack_o
cpu_we_i  in  1  1 = write, 0 = read
cpu_addr_i  in  ADDR_W  byte address
cpu_wdata_i  in  DATA_W  write data
cpu_ack_o  out  1  one-cycle completion pulse
cpu_rdata_o  out  DATA_W  read data, valid with ack
cpu_err_o  out  1  access rejected, valid with ack
cpu_stall_o  out  1  freeze pipeline: cpu_req_i & ~cpu_ack_o
dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i  in  1/1/ADDR_W/DATA_W  debug request, same rules as the CPU port
dbg_ack_o, dbg_rdata_o, dbg_err_o  out  1/DATA_W/1  debug response, same rules as the CPU port
mem_en_o  out  1  memory access strobe
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_W  memory byte address
mem_wdata_o  out  DATA_W  memory write data
mem_rdata_i  in  DATA_W  memory read data, valid the cycle after mem_en_o
wait_cnt_o  out  CNT_W  saturating count of cycles with cpu_stall_o=1

Behaviour:
- Reset (rst_i=0, async): FSM to IDLE; all outputs 0; round-robin pointer set to favour CPU; wait_cnt_o=0. Any in-flight access is abandoned with no ack.
- States: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE: a port is eligible if req_i=1. The CPU port is eligible only when start_i=1 as well.
  - With one eligible port, grant it.
  - With both eligible, grant the port the pointer favours, then move the pointer to the other port.
  - Latch the granted port's we, addr and wdata into internal registers; go to ACCESS.
  - With no eligible port, stay in IDLE.
- Legality check on the latched address: a request is illegal if addr[1:0] != 0 or addr > MEM_BYTES-4.
- ACCESS, legal request: mem_en_o=1 for exactly this cycle; mem_we_o, mem_addr_o and mem_wdata_o come from the latched values.
- ACCESS, illegal request: mem_en_o=0 and the error flag is set.
- In every state other than ACCESS, mem_en_o and mem_we_o are 0.
- RESP: the granted port's ack_o=1 for one cycle.
  - rdata_o = mem_rdata_i for a legal read, otherwise 0.
  - err_o = 1 for an illegal access.
  - Next state is IDLE.
- Latency: req sampled in IDLE at cycle N; ack at cycle N+2. Maximum throughput is one access per 3 cycles. A req still high in the cycle after ack starts a new transaction.
- Once granted, a transaction always completes and acks, even if req_i drops. A requester must keep addr, we and wdata stable until ack; the block samples them only in IDLE.
- rdata_o and err_o hold 0 whenever ack_o=0.
- wait_cnt_o increments every cycle cpu_stall_o=1 and saturates at all-ones. It does not count while the CPU is starved because start_i=0, since that is not a memory stall.
- start_i dropping mid-transaction does not abort a granted CPU access.

Decomposition:
- Shared package dmem_arb_pkg:
  - state enum {IDLE, ACCESS, RESP}
  - port-select constants SEL_CPU=0, SEL_DBG=1
  - helper function addr_legal(addr, MEM_BYTES)
- One sub-module is natural: rr_arb2, a two-requester round-robin picker with a pointer register and an update-on-grant input.

Test Plan:
- Single CPU read: mem word 0x00=5; cpu_req at cycle 1, addr=0, start=1 -> mem_en at cycle 2 with addr 0; cpu_ack and rdata=5 at cycle 3; cpu_stall high cycles 1-2; wait_cnt=2.
- CPU write then read-back: write 0x12345678 to 0x04, then read 0x04 -> mem_we=1 exactly in the first ACCESS cycle; second ack returns 0x12345678, err=0.
- Simultaneous requests held for 4 transactions: both req from reset -> grants CPU, DBG, CPU, DBG; acks at cycles 3, 6, 9, 12.
- Illegal addresses: cpu addr=0x02 and then addr=0x20 -> mem_en never asserted; ack with err=1, rdata=0, each 2 cycles after request sampling.
- start_i=0 with cpu_req and dbg_req high -> only DBG is served; wait_cnt unchanged. Raising start_i then grants CPU on the next IDLE.
- Reset mid-op: assert rst_i low during ACCESS -> all outputs 0 immediately, no ack, wait_cnt=0. After release, a pending req is served normally, with CPU favoured first.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// State codes, port-select codes and the address legality check.
package dmem_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t ACCESS = 2'd1;
  localparam state_t RESP   = 2'd2;

  localparam logic SEL_CPU = 1'b0;
  localparam logic SEL_DBG = 1'b1;

  // Word aligned and the whole word fits below mem_bytes.
  function automatic logic addr_legal(
    input logic [63:0] addr,
    input int unsigned mem_bytes
  );
    logic [63:0] lim;
    lim = 64'(mem_bytes) - 64'd4;
    return (addr[1:0] == 2'b00) && (addr <= lim);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Two-requester round-robin picker.
// The pointer only moves when both requesters competed for a grant.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic [1:0] gnt_o
);

  logic ptr_q;

  always_comb begin
    gnt_o = 2'b00;
    unique case (1'b1)
      (req_i == 2'b11): gnt_o = ptr_q ? 2'b10 : 2'b01;
      (req_i == 2'b01): gnt_o = 2'b01;
      (req_i == 2'b10): gnt_o = 2'b10;
      default:          gnt_o = 2'b00;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr_q <= SEL_CPU;
    end else if (upd_i && (req_i == 2'b11)) begin
      ptr_q <= ~ptr_q;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the CPU MEM stage and debug.
// IDLE -> ACCESS -> RESP per access, round-robin under contention.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter int unsigned MEM_BYTES = 32,
  parameter int          CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_ack_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_err_o,
  output logic              cpu_stall_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_ack_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              dbg_err_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [CNT_W-1:0]  wait_cnt_o
);

  state_t            state_q;
  logic              sel_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
  logic [CNT_W-1:0]  wait_q;

  logic [1:0]        elig;
  logic [1:0]        gnt;
  logic              in_idle;
  logic              in_acc;
  logic              in_resp;
  logic              legal;
  logic [DATA_W-1:0] rsp_data;
  logic              cpu_busy;
  logic              cnt_en;

  assign in_idle = (state_q == IDLE);
  assign in_acc  = (state_q == ACCESS);
  assign in_resp = (state_q == RESP);

  assign elig = {dbg_req_i, cpu_req_i & start_i};

  rr_arb2 u_rr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (elig),
    .upd_i (in_idle),
    .gnt_o (gnt)
  );

  assign legal = addr_legal(64'(addr_q), MEM_BYTES);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      sel_q   <= SEL_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|gnt) begin
            err_q   <= 1'b0;
            state_q <= ACCESS;
            if (gnt[SEL_DBG]) begin
              sel_q   <= SEL_DBG;
              we_q    <= dbg_we_i;
              addr_q  <= dbg_addr_i;
              wdata_q <= dbg_wdata_i;
            end else begin
              sel_q   <= SEL_CPU;
              we_q    <= cpu_we_i;
              addr_q  <= cpu_addr_i;
              wdata_q <= cpu_wdata_i;
            end
          end
        end
        ACCESS: begin
          err_q   <= ~legal;
          state_q <= RESP;
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_en_o    = in_acc & legal;
  assign mem_we_o    = mem_en_o & we_q;
  assign mem_addr_o  = mem_en_o ? addr_q : '0;
  assign mem_wdata_o = mem_en_o ? wdata_q : '0;

  // Writes and rejected accesses return zero data.
  assign rsp_data = (~err_q & ~we_q) ? mem_rdata_i : '0;

  assign cpu_ack_o   = in_resp & (sel_q == SEL_CPU);
  assign cpu_rdata_o = cpu_ack_o ? rsp_data : '0;
  assign cpu_err_o   = cpu_ack_o & err_q;

  assign dbg_ack_o   = in_resp & (sel_q == SEL_DBG);
  assign dbg_rdata_o = dbg_ack_o ? rsp_data : '0;
  assign dbg_err_o   = dbg_ack_o & err_q;

  assign cpu_stall_o = rst_i & cpu_req_i & ~cpu_ack_o;

  // Starvation by start_i=0 is not a memory stall.
  assign cpu_busy = ~in_idle & (sel_q == SEL_CPU);
  assign cnt_en   = cpu_stall_o & (start_i | cpu_busy);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wait_q <= '0;
    end else if (cnt_en && (wait_q != '1)) begin
      wait_q <= wait_q + 1'b1;
    end
  end

  assign wait_cnt_o = wait_q;

endmodule
